// File: rtl/led_arb_pkg.sv
// Shared definitions for the LED bank arbiter: FSM encoding, default bank
// width and the register-width helper used for cnt, ptr and owner.
package led_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t OWN     = 2'd1;
    localparam state_t RELEASE = 2'd2;

    localparam int unsigned LED_W = 10;

    // Register width able to index n values; never narrower than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_bank_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   : request vector, one bit per requester
//   ptr   : highest-priority index for this evaluation
//   valid : at least one request is set
//   idx   : first set request scanning upward from ptr, wrapping at N_REQ
module rr_pick
    import led_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PW    = width_of(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic             valid,
    output logic [PW-1:0]    idx
);

    // Rank each request by its circular distance from ptr; smallest wins.
    always_comb begin
        int best_off;
        int off;
        valid    = 1'b0;
        idx      = '0;
        best_off = int'(N_REQ);
        off      = 0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (req[i]) begin
                off = (i - int'(ptr) + int'(N_REQ)) % int'(N_REQ);
                if (off < best_off) begin
                    best_off = off;
                    idx      = PW'(i);
                    valid    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/led_bank_arbiter.sv
// led_bank_arbiter: round-robin time-sharing of the LEDR bank between N_REQ
// requesters, each owning the bank for at most HOLD_CYCLES cycles.
//   CLOCK_50 : system clock, rising edge
//   resetn   : asynchronous active-low reset
//   req      : level requests, one bit per requester
//   data     : requester i's LED pattern in data[i*W +: W]
//   gnt      : registered one-hot grant
//   done     : registered one-cycle tenure-end pulse
//   LEDR     : registered LED drive
//   busy     : high whenever the FSM is not idle
module led_bank_arbiter
    import led_arb_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned W           = LED_W,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] data,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [W-1:0]       LEDR,
    output logic               busy
);

    localparam int unsigned PW = width_of(N_REQ);
    localparam int unsigned CW = width_of(HOLD_CYCLES);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [PW-1:0]    ptr, ptr_nxt;
    logic [PW-1:0]    owner, owner_nxt;
    logic [N_REQ-1:0] gnt_nxt, done_nxt;
    logic [W-1:0]     led_nxt;

    logic             pick_valid;
    logic [PW-1:0]    pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic [N_REQ-1:0] own_onehot;
    logic             own_req;
    logic [W-1:0]     own_data;
    logic             tenure_end;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Decode the picked and current owner indices, and mux the owner's inputs.
    always_comb begin
        pick_onehot = '0;
        own_onehot  = '0;
        own_req     = 1'b0;
        own_data    = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            pick_onehot[i] = (pick_idx == PW'(i));
            own_onehot[i]  = (owner == PW'(i));
            if (owner == PW'(i)) begin
                own_req  = req[i];
                own_data = data[i*W +: W];
            end
        end
    end

    // Tenure ends on early release or when the hold budget is spent.
    assign tenure_end = !own_req || (cnt == '0);

    // State and datapath registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= '0;
            owner <= '0;
            gnt   <= '0;
            done  <= '0;
            LEDR  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
            gnt   <= gnt_nxt;
            done  <= done_nxt;
            LEDR  <= led_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = OWN;
            OWN:     if (tenure_end) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for counters, pointer, owner and the registered outputs.
    always_comb begin
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        gnt_nxt   = gnt;
        done_nxt  = '0;
        led_nxt   = LEDR;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (pick_valid) begin
                    owner_nxt = pick_idx;
                    gnt_nxt   = pick_onehot;
                    cnt_nxt   = CW'(HOLD_CYCLES - 1);
                end
            end
            OWN: begin
                // The bank is refreshed only while the owner still requests.
                if (own_req) led_nxt = own_data;
                if (tenure_end) begin
                    gnt_nxt  = '0;
                    done_nxt = own_onehot;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            RELEASE: begin
                gnt_nxt = '0;
                ptr_nxt = (owner == PW'(N_REQ - 1)) ? '0 : owner + PW'(1);
            end
            default: begin
                gnt_nxt = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Scoreboard bench for led_bank_arbiter: stimulus queues expected tenures,
// a negedge monitor reconstructs each tenure from gnt/done/LEDR and compares.
module tb_led_bank_arbiter;

    localparam int N  = 4;
    localparam int LW = 10;
    localparam int HC = 8;

    logic            clk;
    logic            resetn;
    logic [N-1:0]    req;
    logic [N*LW-1:0] data;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [LW-1:0]   LEDR;
    logic            busy;

    led_bank_arbiter #(
        .N_REQ       (N),
        .W           (LW),
        .HOLD_CYCLES (HC)
    ) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .req      (req),
        .data     (data),
        .gnt      (gnt),
        .done     (done),
        .LEDR     (LEDR),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        int          len;
        logic [31:0] led2;
        logic [31:0] led_end;
        int          gap;    // -1: gap before this tenure is not checked
    } tenure_t;

    tenure_t exp_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic tenure_t mk(input int idx, input int len, input logic [31:0] led2,
                                   input logic [31:0] led_end, input int gap);
        tenure_t t;
        t.idx = idx; t.len = len; t.led2 = led2; t.led_end = led_end; t.gap = gap;
        return t;
    endfunction

    // Monitor: rebuild each tenure and check it when its done pulse appears.
    int          cur_len  = 0;
    int          zero_run = 0;
    int          seen_idx = 0;
    int          seen_gap = 0;
    logic [31:0] seen_led2;

    always @(negedge clk) begin
        tenure_t e;
        if (!resetn) begin
            cur_len  = 0;
            zero_run = 0;
        end else begin
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            chk("gnt_done_overlap", 32'(gnt & done), 32'd0);
            chk("busy", 32'(busy), 32'((gnt != 0) || (done != 0)));
            if (gnt != 0) begin
                if (cur_len == 0) begin
                    seen_idx = idx_of(gnt);
                    seen_gap = zero_run;
                end else begin
                    chk("gnt_stable", 32'(gnt), 32'(1) << seen_idx);
                end
                cur_len++;
                if (cur_len == 2) seen_led2 = 32'(LEDR);
            end
            if (done != 0) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_done: got 0x%0h expected none at %0t", done, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_onehot", 32'(done), 32'(1) << e.idx);
                    chk("owner", 32'(seen_idx), 32'(e.idx));
                    chk("tenure_len", 32'(cur_len), 32'(e.len));
                    chk("led_end", 32'(LEDR), e.led_end);
                    if (e.len >= 2) chk("led_2nd_cycle", seen_led2, e.led2);
                    if (e.gap >= 0) chk("grant_gap", 32'(seen_gap), 32'(e.gap));
                end
                cur_len  = 0;
                zero_run = 1;
            end else if (gnt == 0) begin
                zero_run++;
            end
        end
    end

    task automatic wait_dones(input int n, input int budget);
        int seen = 0;
        for (int c = 0; c < budget && seen < n; c++) begin
            @(negedge clk);
            if (done != 0) seen++;
        end
        chk("done_count_in_budget", 32'(seen), 32'(n));
    endtask

    task automatic wait_gnt_sample(input int who, input int nth, input int budget);
        int seen = 0;
        for (int c = 0; c < budget && seen < nth; c++) begin
            @(negedge clk);
            if (gnt[who]) seen++;
        end
        chk("gnt_sample_in_budget", 32'(seen), 32'(nth));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"},  32'(gnt),  32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_ledr"}, 32'(LEDR), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        resetn = 1'b0;
        req    = 4'b1111;
        data   = {10'h3C3, 10'h2AA, 10'h155, 10'h011};

        // Reset held with all requests active.
        repeat (3) begin
            @(negedge clk);
            chk_reset_outputs("reset");
        end

        // Single requester 2, held for two tenures.
        exp_q.push_back(mk(2, HC, 32'h2AA, 32'h2AA, -1));
        exp_q.push_back(mk(2, HC, 32'h2AA, 32'h2AA, 2));
        req    = 4'b0100;
        resetn = 1'b1;
        wait_dones(2, 100);
        req = 4'b0000;
        repeat (4) @(negedge clk);

        // Round-robin from reset with every requester active.
        resetn = 1'b0;
        @(negedge clk);
        chk("rst_clears_ledr", 32'(LEDR), 32'd0);
        req = 4'b1111;
        exp_q.push_back(mk(0, HC, 32'h011, 32'h011, -1));
        exp_q.push_back(mk(1, HC, 32'h155, 32'h155, 2));
        exp_q.push_back(mk(2, HC, 32'h2AA, 32'h2AA, 2));
        exp_q.push_back(mk(3, HC, 32'h3C3, 32'h3C3, 2));
        exp_q.push_back(mk(0, HC, 32'h011, 32'h011, 2));
        resetn = 1'b1;
        wait_dones(5, 300);
        req = 4'b0000;
        repeat (3) @(negedge clk);

        // Early release by requester 1 in its 3rd grant cycle; new data must not reach LEDR.
        exp_q.push_back(mk(1, 3, 32'h155, 32'h155, -1));
        req = 4'b1010;
        wait_gnt_sample(1, 3, 50);
        req = 4'b1000;
        data[1*LW +: LW] = 10'h0F0;

        // Requester 3 is served next; reset lands in its 5th cycle.
        wait_gnt_sample(3, 5, 50);
        resetn = 1'b0;
        #1;
        chk_reset_outputs("mid_tenure_reset");
        @(negedge clk);
        chk("no_done_in_reset", 32'(done), 32'd0);

        // After reset ptr is 0, so requester 1 wins, then 3, then the pointer wraps to 0.
        data[1*LW +: LW] = 10'h155;
        req = 4'b1010;
        exp_q.push_back(mk(1, HC, 32'h155, 32'h155, -1));
        exp_q.push_back(mk(3, HC, 32'h3C3, 32'h3C3, 2));
        resetn = 1'b1;
        wait_dones(2, 100);
        req = 4'b1001;
        exp_q.push_back(mk(0, HC, 32'h011, 32'h011, 2));
        wait_dones(1, 50);
        req = 4'b0000;
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
